// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ID-stage branch logic: branch opcodes,
// the branch-sequencer state encoding and the rt-usage decode.
package mips_pkg;

  localparam logic [5:0] OP_BLTZ = 6'h01;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ = 6'h07;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STALL,
    ST_RESOLVED
  } br_state_e;

  // Compare-against-zero branches carry a don't-care rt field.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return !((opcode == OP_BLEZ) || (opcode == OP_BGTZ) || (opcode == OP_BLTZ));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous hold and asynchronous active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (inc && !hold && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/branch_sched_ctrl.sv
// ID-stage branch sequencer: stalls until branch operands are forwardable,
// then issues the PC redirect and IF/ID flush, and keeps branch statistics.
module branch_sched_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Branch_ID,
  input  logic [REG_W-1:0] Rs_ID,
  input  logic [REG_W-1:0] Rt_ID,
  input  logic [5:0]       OpCode_ID,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [REG_W-1:0] Rd_EX,
  input  logic             RegWrite_MEM,
  input  logic             MemRead_MEM,
  input  logic [REG_W-1:0] Rd_MEM,
  input  logic             Zero,
  input  logic             Hold_ext,
  output logic             Stall_Br,
  output logic             PCSrc_Br,
  output logic             Flush_IFID,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] TakenCnt,
  output logic [CNT_W-1:0] StallCnt
);

  br_state_e  state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic [1:0] depth;
  logic       hit_ex, hit_mem, rt_used;
  logic       stall, pcsrc, flush, resolve;

  // Register $0 never creates a dependency.
  assign rt_used = uses_rt(OpCode_ID);
  assign hit_ex  = ((Rs_ID != '0) && (Rs_ID == Rd_EX)) ||
                   (rt_used && (Rt_ID != '0) && (Rt_ID == Rd_EX));
  assign hit_mem = ((Rs_ID != '0) && (Rs_ID == Rd_MEM)) ||
                   (rt_used && (Rt_ID != '0) && (Rt_ID == Rd_MEM));

  always_comb begin
    depth = 2'd0;
    if (MemRead_EX && hit_ex)
      depth = 2'd2;
    else if ((RegWrite_EX && hit_ex) || (MemRead_MEM && hit_mem))
      depth = 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: every output of this block is defaulted first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    pcsrc    = 1'b0;
    flush    = 1'b0;
    resolve  = 1'b0;
    if (!Hold_ext) begin
      unique case (state)
        ST_IDLE: begin
          if (Branch_ID) begin
            if (depth != 2'd0) begin
              stall = 1'b1;
              if (depth != 2'd1) begin
                state_nx = ST_STALL;
                cnt_nx   = depth - 2'd1;
              end
            end else begin
              resolve  = 1'b1;
              pcsrc    = Zero;
              flush    = Zero;
              state_nx = ST_RESOLVED;
            end
          end
        end
        ST_STALL: begin
          stall  = 1'b1;
          cnt_nx = cnt - 2'd1;
          if (cnt <= 2'd1)
            state_nx = ST_IDLE;
        end
        ST_RESOLVED: state_nx = ST_IDLE;
        default:     state_nx = ST_IDLE;
      endcase
    end
  end

  // The IDLE outputs are Mealy, so they must be masked while reset is held.
  assign Stall_Br   = stall & ~reset;
  assign PCSrc_Br   = pcsrc & ~reset;
  assign Flush_IFID = flush & ~reset;

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk(clk), .reset(reset), .inc(resolve), .hold(Hold_ext), .count(BranchCnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk(clk), .reset(reset), .inc(resolve & Zero), .hold(Hold_ext), .count(TakenCnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall), .hold(Hold_ext), .count(StallCnt)
  );

endmodule

// File: doc/branch_sched_ctrl.md
Name: branch_sched_ctrl

Overview:
- Sequences ID-stage branch resolution for the 5-stage MIPS pipeline.
- Detects when a branch's source operands are still in flight in EX or MEM, and stalls IF/ID for the required number of cycles.
- Once operands are forwardable, samples the branch-compare result (Zero) and issues the PC redirect plus a one-cycle IF/ID flush.
- Keeps saturating statistics counters for branches, taken branches and branch-stall cycles.

Parameters:
- CNT_W, 16, width of each statistics counter.
- REG_W, 5, register-specifier width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- Branch_ID  in  1  instruction in ID is a branch (beq/bne/blez/bgtz/bltz).
- Rs_ID  in  REG_W  branch source register 1.
- Rt_ID  in  REG_W  branch source register 2; ignored when OpCode_ID is 0x06, 0x07 or 0x01.
- OpCode_ID  in  6  opcode of the ID instruction.
- RegWrite_EX  in  1  EX-stage instruction writes the register file.
- MemRead_EX  in  1  EX-stage instruction is a load.
- Rd_EX  in  REG_W  EX-stage destination register.
- RegWrite_MEM  in  1  MEM-stage instruction writes the register file.
- MemRead_MEM  in  1  MEM-stage instruction is a load.
- Rd_MEM  in  REG_W  MEM-stage destination register.
- Zero  in  1  branch-condition result from the ID compare unit.
- Hold_ext  in  1  external pipeline freeze (cache/IO); FSM and counters hold.
- Stall_Br  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- PCSrc_Br  out  1  select branch target for the next PC.
- Flush_IFID  out  1  zero the IF/ID register on the next edge.
- BranchCnt  out  CNT_W  resolved branches.
- TakenCnt  out  CNT_W  taken branches.
- StallCnt  out  CNT_W  cycles with Stall_Br=1.

Behaviour:
Hazard depth n:
- A source register matches only if it is nonzero and in use.
- n = 2 if MemRead_EX and Rd_EX matches a source.
- else n = 1 if (RegWrite_EX and Rd_EX matches) or (MemRead_MEM and Rd_MEM matches).
- else n = 0.
- ALU results in MEM and all WB values are forwarded, or written first-half in the register file, so they need no stall.

States:
- IDLE, STALL (down-counter cnt, 2 bits), RESOLVED.
- Outputs are Mealy in IDLE and Moore in STALL and RESOLVED.

IDLE:
- Branch_ID=0: all control outputs 0.
- Branch_ID=1 and n>0: Stall_Br=1; next state STALL with cnt=n-1; if n-1=0, next state IDLE instead (re-evaluate).
- Branch_ID=1 and n=0: resolve this cycle.
  - PCSrc_Br=Zero, Flush_IFID=Zero.
  - BranchCnt+1; TakenCnt+1 if Zero.
  - Next state RESOLVED.

STALL:
- Stall_Br=1.
- cnt decrements; go to IDLE when cnt=1, then re-evaluate next cycle.

RESOLVED:
- All control outputs 0, for exactly one cycle; return to IDLE.
- Guards against re-resolving the same branch if IF/ID is held externally.
- A Branch_ID=1 seen in this state is ignored and picked up in IDLE next cycle.

Hold_ext=1:
- State, cnt and counters freeze.
- All control outputs forced 0.
- A pending resolution waits for Hold_ext=0.

StallCnt:
- Increments each cycle Stall_Br=1.
- All counters saturate at all-ones, with no wrap.

Reset:
- Asynchronous at any time, including mid-STALL.
- State=IDLE, cnt=0, all counters 0.
- Stall_Br, PCSrc_Br, Flush_IFID read 0 while reset is high.

Zero is never sampled while Stall_Br=1.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_BEQ=0x04, OP_BNE=0x05, OP_BLEZ=0x06, OP_BGTZ=0x07, OP_BLTZ=0x01;
  - the state enum;
  - function uses_rt(opcode).
- One sub-module, sat_counter (width CNT_W, inc enable, synchronous hold, async reset), instantiated three times.

Test Plan:
- beq $1,$2 with no in-flight writer, Zero=1 -> same cycle PCSrc_Br=1, Flush_IFID=1, Stall_Br=0; BranchCnt=1, TakenCnt=1.
- add $3 in EX, then bne $3,$4 in ID -> Stall_Br=1 for exactly 1 cycle; resolves next cycle; StallCnt=1.
- lw $5 in EX, then beq $5,$0 in ID -> Stall_Br high 2 cycles; resolution on 3rd cycle with Zero=0 -> PCSrc_Br=0, BranchCnt=1, TakenCnt=0.
- bgtz $6 with Rt_ID=6'd7 and an EX writer of $7 -> n=0, no stall (Rt unused); Rd_EX=0 with RegWrite_EX -> no stall.
- Reset asserted during the 2nd cycle of a 2-cycle load stall -> outputs 0 immediately; after release, state IDLE and all counters 0.
- Hold_ext=1 for 3 cycles while a branch is in ID with n=0 -> no outputs, counters unchanged; on release, a single resolution (BranchCnt +1 only).
